// File: rtl/sonar_pkg.sv
// rtl/sonar_pkg.sv - shared state encoding and default timing constants for the sonar ranger
package sonar_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TX,
    ST_BLANK,
    ST_LISTEN,
    ST_REPORT
  } sonar_state_e;

  // Defaults assume a 32 MHz clk_32.
  localparam int DEF_WF_HALF   = 392;
  localparam int DEF_TX_CYCLES = 8000;
  localparam int DEF_BLANK     = 70000;
  localparam int DEF_HOLDOFF   = 2000;
  localparam int DEF_MAX_RANGE = 2000000;
  localparam int DEF_ECHOES    = 4;
  localparam int DEF_CNT_W     = 22;

endpackage

// File: rtl/sonar_sync_edge.sv
// rtl/sonar_sync_edge.sv - two-flop synchroniser with history flop and rising-edge detect
module sonar_sync_edge (
  input  logic clk_32,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic       sync1;
  logic       sync2;
  logic       hist;
  logic [2:0] fill;

  // fill gates the detector until hist holds a real sample, so an input
  // already high when reset releases is not mistaken for an edge.
  always_ff @(posedge clk_32 or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      hist  <= 1'b0;
      fill  <= 3'b000;
    end else begin
      sync1 <= d;
      sync2 <= sync1;
      hist  <= sync2;
      fill  <= {fill[1:0], 1'b1};
    end
  end

  assign rise = fill[2] & sync2 & ~hist;

endmodule

// File: rtl/sonar_ranger.sv
// rtl/sonar_ranger.sv - ultrasonic ping sequencer: transmit burst, blanking, echo capture and result handshake
module sonar_ranger
  import sonar_pkg::*;
#(
  parameter int WF_HALF   = DEF_WF_HALF,
  parameter int TX_CYCLES = DEF_TX_CYCLES,
  parameter int BLANK     = DEF_BLANK,
  parameter int HOLDOFF   = DEF_HOLDOFF,
  parameter int MAX_RANGE = DEF_MAX_RANGE,
  parameter int ECHOES    = DEF_ECHOES,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic             clk_32,
  input  logic             rst_n,
  input  logic             trigger,
  input  logic             rx_in,
  output logic             tx_pulse,
  output logic             tx_oe,
  output logic             rx_out,
  output logic             rng_pwm,
  output logic             busy,
  output logic             echo_valid,
  input  logic             echo_ready,
  output logic [CNT_W-1:0] echo_range,
  output logic [2:0]       echo_idx,
  output logic             echo_last,
  output logic             timeout
);

  localparam bit PARAMS_OK = (TX_CYCLES >= 1) && (WF_HALF >= 1) &&
                             (TX_CYCLES < BLANK) && (BLANK < MAX_RANGE) &&
                             (64'(MAX_RANGE) < (64'd1 << CNT_W)) &&
                             (HOLDOFF >= 0) && (HOLDOFF < MAX_RANGE) &&
                             (ECHOES >= 1) && (ECHOES <= 8);

  if (!PARAMS_OK) begin : g_bad_params
    $error("sonar_ranger: illegal parameter set");
  end

  localparam logic [CNT_W-1:0] TX_END    = CNT_W'(TX_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK - 1);
  localparam logic [CNT_W-1:0] RANGE_END = CNT_W'(MAX_RANGE - 1);
  localparam logic [CNT_W-1:0] RANGE_MAX = CNT_W'(MAX_RANGE);
  localparam logic [CNT_W-1:0] HOLD_PRE  = CNT_W'((HOLDOFF == 0) ? 0 : HOLDOFF - 1);
  localparam logic [CNT_W-1:0] WF_END    = CNT_W'(WF_HALF - 1);
  localparam logic [3:0]       ECHO_MAX  = 4'(ECHOES);
  localparam logic [3:0]       ECHO_LAST = 4'(ECHOES - 1);

  sonar_state_e     state;
  sonar_state_e     state_nxt;
  logic [CNT_W-1:0] pri_count;
  logic [CNT_W-1:0] wf_cnt;
  logic             wf;
  logic [3:0]       ecnt;
  logic [2:0]       rd_idx;
  logic             pwm_q;
  logic             rx_out_q;
  logic [CNT_W-1:0] echo_buf [8];

  logic trig_rise;
  logic rx_rise;
  logic counting;
  logic capture;
  logic first_capture;
  logic accept;
  logic last_entry;
  logic leave_listen;

  sonar_sync_edge u_trig_sync (
    .clk_32 (clk_32),
    .rst_n  (rst_n),
    .d      (trigger),
    .rise   (trig_rise)
  );

  sonar_sync_edge u_rx_sync (
    .clk_32 (clk_32),
    .rst_n  (rst_n),
    .d      (rx_in),
    .rise   (rx_rise)
  );

  assign counting      = (state == ST_TX) || (state == ST_BLANK) || (state == ST_LISTEN);
  assign capture       = (state == ST_LISTEN) && rx_rise && (ecnt < ECHO_MAX);
  assign first_capture = capture && (ecnt == 4'd0);
  assign accept        = (state == ST_REPORT) && echo_ready;
  assign last_entry    = (ecnt == 4'd0) || ({1'b0, rd_idx} == (ecnt - 4'd1));
  assign leave_listen  = (state == ST_LISTEN) && (state_nxt != ST_LISTEN);

  always_ff @(posedge clk_32 or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:   if (trig_rise) state_nxt = ST_TX;
      ST_TX:     if (pri_count == TX_END) state_nxt = ST_BLANK;
      ST_BLANK:  if (pri_count == BLANK_END) state_nxt = ST_LISTEN;
      ST_LISTEN: begin
        if ((pri_count == RANGE_END) || (capture && (ecnt == ECHO_LAST))) begin
          state_nxt = ST_REPORT;
        end
      end
      ST_REPORT: if (accept && last_entry) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_32 or negedge rst_n) begin
    if (!rst_n) begin
      pri_count <= '0;
      wf_cnt    <= '0;
      wf        <= 1'b0;
      ecnt      <= 4'd0;
      rd_idx    <= 3'd0;
      rx_out_q  <= 1'b0;
    end else begin
      rx_out_q <= capture;
      if ((state == ST_IDLE) && trig_rise) begin
        pri_count <= '0;
        wf_cnt    <= '0;
        wf        <= 1'b1;
        ecnt      <= 4'd0;
        rd_idx    <= 3'd0;
      end else begin
        if (counting) begin
          if (pri_count != '1) pri_count <= pri_count + 1'b1;
          // Phase is a pure function of pri_count, so every ping starts identically.
          if (wf_cnt == WF_END) begin
            wf_cnt <= '0;
            wf     <= ~wf;
          end else begin
            wf_cnt <= wf_cnt + 1'b1;
          end
        end
        if (capture) ecnt <= ecnt + 4'd1;
        if (accept && !last_entry) rd_idx <= rd_idx + 3'd1;
      end
    end
  end

  // Echo capture clears the range pulse ahead of any other update that cycle.
  always_ff @(posedge clk_32 or negedge rst_n) begin
    if (!rst_n) begin
      pwm_q <= 1'b0;
    end else if ((state == ST_IDLE) && trig_rise) begin
      pwm_q <= (HOLDOFF == 0);
    end else if (first_capture || leave_listen) begin
      pwm_q <= 1'b0;
    end else if (counting && (HOLDOFF != 0) && (pri_count == HOLD_PRE) && (ecnt == 4'd0)) begin
      pwm_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_32) begin
    if (capture) echo_buf[ecnt[2:0]] <= pri_count;
  end

  assign tx_oe      = (state == ST_TX);
  assign tx_pulse   = tx_oe & wf;
  assign rx_out     = rx_out_q;
  assign rng_pwm    = pwm_q & ~first_capture;
  assign busy       = (state != ST_IDLE);
  assign echo_valid = (state == ST_REPORT);
  assign timeout    = echo_valid && (ecnt == 4'd0);
  assign echo_last  = echo_valid && last_entry;
  assign echo_idx   = echo_valid ? rd_idx : 3'd0;
  assign echo_range = !echo_valid ? '0 : (timeout ? RANGE_MAX : echo_buf[rd_idx]);

endmodule

// File: tb/tb_sonar_ranger.sv
// tb/tb_sonar_ranger.sv - table-driven self-checking bench for sonar_ranger
module tb_sonar_ranger;

  localparam int CNT_W = 22;

  logic             clk_32;
  logic             rst_n;
  logic             trigger;
  logic             rx_in;
  logic             tx_pulse;
  logic             tx_oe;
  logic             rx_out;
  logic             rng_pwm;
  logic             busy;
  logic             echo_valid;
  logic             echo_ready;
  logic [CNT_W-1:0] echo_range;
  logic [2:0]       echo_idx;
  logic             echo_last;
  logic             timeout;

  int n_cmp = 0;
  int n_bad = 0;

  sonar_ranger #(
    .WF_HALF   (4),
    .TX_CYCLES (32),
    .BLANK     (64),
    .HOLDOFF   (8),
    .MAX_RANGE (256),
    .ECHOES    (2),
    .CNT_W     (CNT_W)
  ) dut (
    .clk_32     (clk_32),
    .rst_n      (rst_n),
    .trigger    (trigger),
    .rx_in      (rx_in),
    .tx_pulse   (tx_pulse),
    .tx_oe      (tx_oe),
    .rx_out     (rx_out),
    .rng_pwm    (rng_pwm),
    .busy       (busy),
    .echo_valid (echo_valid),
    .echo_ready (echo_ready),
    .echo_range (echo_range),
    .echo_idx   (echo_idx),
    .echo_last  (echo_last),
    .timeout    (timeout)
  );

  initial clk_32 = 1'b0;
  always #5 clk_32 = ~clk_32;

  typedef struct {
    int e0, e1, e2;   // pri_count at which each rx edge is seen (-1 = none)
    int stall;        // cycles echo_ready is held low on the first result
    int n_res;
    int r0, r1;
    bit to;
    int n_rx;         // expected rx_out pulses
    int pwm;          // expected rng_pwm high cycles
    int vat;          // pri_count-relative cycle at which REPORT starts
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string name);
    logic [CNT_W+11:0] all;
    all = {tx_oe, tx_pulse, rx_out, rng_pwm, busy, echo_valid, echo_last, timeout,
           echo_idx, echo_range, 1'b0};
    chk(name, all, 0);
  endtask

  task automatic start_ping(output bit ok);
    trigger = 1'b0;
    repeat (3) @(negedge clk_32);
    trigger = 1'b1;
    for (int i = 0; i < 10 && !busy; i++) @(negedge clk_32);
    ok = busy;
    if (!ok) chk("start_busy_timeout", 0, 1);
    trigger = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int id);
    bit     ok;
    int     es [3];
    int     vat, txoe_n, txp_hi, txp_rise, rxo_n, pwm_n;
    logic   prev_p;
    longint r_exp, r_hold, i_hold;
    bit     stable, ign;
    es = '{v.e0, v.e1, v.e2};
    vat = -1; txoe_n = 0; txp_hi = 0; txp_rise = 0; rxo_n = 0; pwm_n = 0;
    prev_p = 1'b0;
    start_ping(ok);
    if (!ok) return;
    chk($sformatf("v%0d_tx_start_high", id), tx_pulse, 1);
    for (int k = 0; k <= 400; k++) begin
      txoe_n += int'(tx_oe);
      txp_hi += int'(tx_pulse);
      if (tx_pulse && !prev_p) txp_rise++;
      prev_p = tx_pulse;
      rxo_n += int'(rx_out);
      pwm_n += int'(rng_pwm);
      if (echo_valid) begin
        vat = k;
        break;
      end
      foreach (es[j]) begin
        if (es[j] >= 0) begin
          if (k == es[j] - 2) rx_in = 1'b1;
          if (k == es[j]) rx_in = 1'b0;
        end
      end
      @(negedge clk_32);
    end
    rx_in = 1'b0;
    if (vat < 0) begin
      chk($sformatf("v%0d_report_timeout", id), 0, 1);
      return;
    end
    chk($sformatf("v%0d_report_cycle", id), vat, v.vat);
    chk($sformatf("v%0d_tx_oe_cycles", id), txoe_n, 32);
    chk($sformatf("v%0d_tx_high_cycles", id), txp_hi, 16);
    chk($sformatf("v%0d_tx_periods", id), txp_rise, 4);
    chk($sformatf("v%0d_rx_out_pulses", id), rxo_n, v.n_rx);
    chk($sformatf("v%0d_pwm_width", id), pwm_n, v.pwm);

    for (int i = 0; i < v.n_res; i++) begin
      r_exp = (i == 0) ? v.r0 : v.r1;
      if (i == 0 && v.stall > 0) begin
        r_hold = echo_range;
        i_hold = echo_idx;
        stable = 1'b1;
        for (int s = 0; s < v.stall; s++) begin
          if (s == 2) trigger = 1'b1;
          @(negedge clk_32);
          if (echo_range != r_hold || echo_idx != i_hold || !busy || !echo_valid) stable = 1'b0;
        end
        chk($sformatf("v%0d_stall_stable", id), stable, 1);
      end
      chk($sformatf("v%0d_valid%0d", id, i), echo_valid, 1);
      chk($sformatf("v%0d_range%0d", id, i), echo_range, r_exp);
      chk($sformatf("v%0d_idx%0d", id, i), echo_idx, i);
      chk($sformatf("v%0d_last%0d", id, i), echo_last, (i == v.n_res - 1));
      chk($sformatf("v%0d_timeout%0d", id, i), timeout, v.to);
      echo_ready = 1'b1;
      @(negedge clk_32);
      echo_ready = 1'b0;
    end
    chk($sformatf("v%0d_idle_after_last", id), busy, 0);
    if (v.stall > 0) begin
      ign = 1'b1;
      repeat (6) begin
        @(negedge clk_32);
        if (busy) ign = 1'b0;
      end
      chk($sformatf("v%0d_retrigger_ignored", id), ign, 1);
      trigger = 1'b0;
    end
  endtask

  initial begin
    bit ok;
    bit quiet;
    //            e0   e1   e2  stall n  r0   r1  to nrx pwm  vat
    tbl[0] = '{  -1,  -1,  -1,  0,  1, 256,   0, 1, 0, 248, 256};
    tbl[1] = '{ 100, 150,  -1,  0,  2, 100, 150, 0, 2,  92, 151};
    tbl[2] = '{  40, 120,  -1,  0,  1, 120,   0, 0, 1, 112, 256};
    tbl[3] = '{ 100, 150,  -1, 10,  2, 100, 150, 0, 2,  92, 151};
    tbl[4] = '{ 255,  -1,  -1,  0,  1, 255,   0, 0, 1, 247, 256};
    tbl[5] = '{  63,  68,  -1,  0,  1,  68,   0, 0, 1,  60, 256};
    tbl[6] = '{  20, 100, 150,  0,  2, 100, 150, 0, 2,  92, 151};

    rst_n = 1'b0; trigger = 1'b0; rx_in = 1'b0; echo_ready = 1'b0;
    repeat (3) @(negedge clk_32);
    chk_reset_outputs("reset_outputs");
    rst_n = 1'b1;
    repeat (3) @(negedge clk_32);
    chk("idle_after_reset", busy, 0);

    // Reset mid-transmit, then trigger held high across reset release.
    start_ping(ok);
    if (ok) begin
      repeat (10) @(negedge clk_32);
      chk("tx_oe_before_reset", tx_oe, 1);
      rst_n = 1'b0;
      #1;
      chk("tx_oe_released_by_reset", tx_oe, 0);
      chk_reset_outputs("midping_reset_outputs");
      trigger = 1'b1;
      @(negedge clk_32);
      rst_n = 1'b1;
      quiet = 1'b1;
      repeat (12) begin
        @(negedge clk_32);
        if (busy) quiet = 1'b0;
      end
      chk("held_trigger_ignored", quiet, 1);
      trigger = 1'b0;
    end

    for (int i = 0; i < 7; i++) run_vec(tbl[i], i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

endmodule
